pool_ctrl: RTL
==============

POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 SHALL have parameter CNT_MAX, default 68, meaning the index of the last conv beat per frame.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port start, input, 1, a frame-start request pulse.
REQ-005 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-006 SHALL have port done, output, 1, a one-cycle pulse at frame end.
REQ-007 SHALL have port conv_vld, input, 1, meaning the upstream conv beat is valid.
REQ-008 SHALL have port conv_rdy, output, 1, meaning pool_ctrl accepts a conv beat.
REQ-009 SHALL have port pool_in_vld, output, 1, the beat strobe to the pool datapath.
REQ-010 SHALL have port pool_cnt, output, 7, the index of the current beat, 0..CNT_MAX.
REQ-011 SHALL have port row_vld, output, 1, meaning the pooled row in the pool registers is complete.
REQ-012 SHALL have port row_rdy, input, 1, meaning downstream takes the pooled row.
REQ-013 SHALL have port row_idx, output, 2, the pooled row number 0..2.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-015 SHALL go IDLE->RUN on start; start SHALL be ignored in any other state.
REQ-016 SHALL go RUN->DRAIN on the edge accepting the beat with pool_cnt=CNT_MAX.
REQ-017 SHALL go DRAIN->DONE once row_vld is low or is handshaken in that cycle.
REQ-018 SHALL go DONE->IDLE unconditionally after one cycle; done SHALL be high only in DONE.
REQ-019 SHALL drive busy high in RUN and DRAIN.
REQ-020 SHALL form accept as conv_vld && conv_rdy; pool_in_vld SHALL equal accept combinationally.
REQ-021 SHALL drive conv_rdy high only in RUN, except it SHALL be low when row_vld && !row_rdy && pool_cnt is 37 or 53 (next-row start, which would overwrite the pool registers).
REQ-022 SHALL clear pool_cnt to 0 on entering RUN and increment it by 1 per accept, with no wrap past CNT_MAX.
REQ-023 SHALL set row_vld on the edge accepting pool_cnt 34, 50 or 66, with row_idx 0, 1, 2 respectively.
REQ-024 SHALL clear row_vld on the edge where row_vld && row_rdy.
REQ-025 SHALL give set priority over clear when set and clear occur on the same edge; this case is unreachable given REQ-021 but still required.
REQ-026 SHALL hold row_idx stable while row_vld is high.
REQ-027 SHALL keep pool_cnt and conv_rdy constant on conv_vld low (no accept), i.e. insert a bubble.

Reset
REQ-028 SHALL on rst force IDLE, busy=0, done=0, conv_rdy=0, pool_cnt=0, row_vld=0 and row_idx=0, including mid-frame; rst SHALL dominate start.

Configuration
REQ-029 SHALL support macro POOL_CTRL_FRAME_CNT_EN: when defined, it adds output frame_cnt[15:0], reset 0, incremented in DONE and wrapping 0xFFFF->0; when undefined, there is no port and no logic.

Structure
REQ-030 SHALL put CNT_MAX default, row-end constants {34,50,66}, next-row-start constants {37,53} and the FSM state enum in shared package pool_pkg.
REQ-031 SHALL contain one sub-module, pool_beat_cnt (the accept counter with saturation at CNT_MAX); everything else is flat.

Verification
REQ-032 SHALL verify: start, conv_vld held high, row_rdy held high -> 69 accepts, row_vld for one cycle after cnt 34/50/66 with row_idx 0/1/2, and done one cycle after DRAIN.
REQ-033 SHALL verify: row_rdy low from cnt 34 -> conv_rdy drops at pool_cnt=37, and raising row_rdy resumes acceptance the next cycle with pool_cnt=37 unchanged.
REQ-034 SHALL verify: conv_vld toggling 1/0 -> pool_cnt advances only on accept, and the frame still completes at 69 accepts.
REQ-035 SHALL verify: rst asserted at pool_cnt=40 -> next cycle IDLE, with all outputs zero, and a new start runs a clean frame.
REQ-036 SHALL verify: start pulsed during RUN and DONE -> ignored, so there is no pool_cnt restart.
REQ-037 SHALL verify, with POOL_CTRL_FRAME_CNT_EN defined: 3 back-to-back frames give frame_cnt=3.

Source files
------------

// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared constants and types for the pooling-controller slice.
//   CNT_MAX_DEF           : default index of the last conv beat in a frame
//   ROW_END0..2           : beat indices whose acceptance completes pooled row 0..2
//   ROW_START1..2         : beat indices that begin writing the next pooled row
//   pool_state_e          : frame FSM states
//   is_next_row_start()   : true when a beat index would start overwriting the
//                           pool registers with a new row
// -----------------------------------------------------------------------------
package pool_pkg;

   localparam int unsigned CNT_MAX_DEF = 68;

   localparam logic [6:0] ROW_END0   = 7'd34;
   localparam logic [6:0] ROW_END1   = 7'd50;
   localparam logic [6:0] ROW_END2   = 7'd66;

   localparam logic [6:0] ROW_START1 = 7'd37;
   localparam logic [6:0] ROW_START2 = 7'd53;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } pool_state_e;

   function automatic logic is_next_row_start(input logic [6:0] cnt);
      return (cnt == ROW_START1) || (cnt == ROW_START2);
   endfunction

endpackage

// File: rtl/pool_ctrl_if.sv
// -----------------------------------------------------------------------------
// pool_ctrl_if
// Beat/row handshake bundle between pool_ctrl and its neighbours.
//   conv_vld    : upstream conv beat valid            (into pool_ctrl)
//   conv_rdy    : pool_ctrl accepts a conv beat        (from pool_ctrl)
//   pool_in_vld : beat strobe to the pool datapath     (from pool_ctrl)
//   pool_cnt    : index of the current beat, 0..CNT_MAX(from pool_ctrl)
//   row_vld     : pooled row complete in pool registers(from pool_ctrl)
//   row_rdy     : downstream takes the pooled row      (into pool_ctrl)
//   row_idx     : pooled row number 0..2               (from pool_ctrl)
// Modports: master = pool_ctrl side, slave = upstream/downstream side.
// -----------------------------------------------------------------------------
interface pool_ctrl_if;

   logic       conv_vld;
   logic       conv_rdy;
   logic       pool_in_vld;
   logic [6:0] pool_cnt;
   logic       row_vld;
   logic       row_rdy;
   logic [1:0] row_idx;

   modport master (
      input  conv_vld,
      input  row_rdy,
      output conv_rdy,
      output pool_in_vld,
      output pool_cnt,
      output row_vld,
      output row_idx
   );

   modport slave (
      output conv_vld,
      output row_rdy,
      input  conv_rdy,
      input  pool_in_vld,
      input  pool_cnt,
      input  row_vld,
      input  row_idx
   );

endinterface

// File: rtl/pool_beat_cnt.sv
// -----------------------------------------------------------------------------
// pool_beat_cnt
// Accepted-beat counter for one frame; saturates at CNT_MAX (never wraps).
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   clr_i : clear to 0 (frame start)
//   inc_i : increment by one (beat accepted)
//   cnt_o : current beat index
// -----------------------------------------------------------------------------
module pool_beat_cnt
   import pool_pkg::*;
#(
   parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       inc_i,
   output logic [6:0] cnt_o
);

   localparam logic [6:0] CNT_LAST = 7'(CNT_MAX);

   logic [6:0] cnt_q;
   logic [6:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < CNT_LAST)) begin
         cnt_d = cnt_q + 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pool_ctrl.sv
// -----------------------------------------------------------------------------
// pool_ctrl
// Frame controller for the pooling stage: accepts CNT_MAX+1 conv beats per
// frame, flags each completed pooled row to downstream, and stalls upstream
// before a new row would overwrite a row that has not yet been taken.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (dominates start)
//   start     : frame-start request pulse, honoured only in IDLE
//   busy      : high in RUN and DRAIN
//   done      : one-cycle pulse in DONE
//   frame_cnt : completed-frame counter, 16-bit wrapping
//               (present only when POOL_CTRL_FRAME_CNT_EN is defined)
//   pool_bus  : beat/row handshake bundle (pool_ctrl_if.master)
// Optional feature macro: POOL_CTRL_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module pool_ctrl
   import pool_pkg::*;
#(
   parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
`ifdef POOL_CTRL_FRAME_CNT_EN
   output logic [15:0] frame_cnt,
`endif
   pool_ctrl_if.master pool_bus
);

   localparam logic [6:0] CNT_LAST = 7'(CNT_MAX);

   pool_state_e state_q, state_d;
   logic        row_vld_q, row_vld_d;
   logic [1:0]  row_idx_q, row_idx_d;

   logic [6:0]  cnt;
   logic        cnt_clr;
   logic        conv_rdy;
   logic        accept;

   pool_beat_cnt #(
      .CNT_MAX (CNT_MAX)
   ) u_beat_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .inc_i (accept),
      .cnt_o (cnt)
   );

   always_comb begin
      state_d   = state_q;
      row_vld_d = row_vld_q;
      row_idx_d = row_idx_q;
      cnt_clr   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      // Hold off the first beat of the next row while the previous pooled
      // row is still sitting un-taken in the pool registers.
      conv_rdy = (state_q == ST_RUN) &&
                 !(row_vld_q && !pool_bus.row_rdy && is_next_row_start(cnt));
      accept   = pool_bus.conv_vld && conv_rdy;

      // Clear first, then set, so a same-edge set wins.
      if (row_vld_q && pool_bus.row_rdy) begin
         row_vld_d = 1'b0;
      end
      if (accept) begin
         unique case (cnt)
            ROW_END0: begin row_vld_d = 1'b1; row_idx_d = 2'd0; end
            ROW_END1: begin row_vld_d = 1'b1; row_idx_d = 2'd1; end
            ROW_END2: begin row_vld_d = 1'b1; row_idx_d = 2'd2; end
            default:  ;
         endcase
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_clr = 1'b1;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (accept && (cnt == CNT_LAST)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (!row_vld_q || pool_bus.row_rdy) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         row_vld_q <= 1'b0;
         row_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         row_vld_q <= row_vld_d;
         row_idx_q <= row_idx_d;
      end
   end

`ifdef POOL_CTRL_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else if (state_q == ST_DONE) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   // Frame counter not built in this configuration.
`endif

   assign pool_bus.conv_rdy    = conv_rdy;
   assign pool_bus.pool_in_vld = accept;
   assign pool_bus.pool_cnt    = cnt;
   assign pool_bus.row_vld     = row_vld_q;
   assign pool_bus.row_idx     = row_idx_q;

endmodule
